// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcodes, immediate/ALU selectors, ID-stage states
// and the decoded control bundle carried from decode into the ID register.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [2:0] {
        IMM_I       = 3'd0,
        IMM_S       = 3'd1,
        IMM_B       = 3'd2,
        IMM_U       = 3'd3,
        IMM_J       = 3'd4,
        IMM_SHAMT   = 3'd6,
        IMM_ILLEGAL = 3'd7
    } imm_sel_t;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FULL   = 2'd1,
        ST_HAZARD = 2'd2
    } id_state_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        alu_op_t    alu_op;
        imm_sel_t   imm_sel;
        logic       use_imm;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_CLEAR = '0;

    // Only the two base-ISA funct7 encodings are legal for R-type and shifts.
    function automatic logic funct7_ok(input logic [6:0] f7);
        return (f7 == F7_BASE) || (f7 == F7_ALT);
    endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational RV32I decoder: instruction word to control bundle, plus which
// source registers the instruction actually reads (for load-use detection).
module rv_decoder
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        rs1_used,
    output logic        rs2_used
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       bad;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        ctrl         = CTRL_CLEAR;
        ctrl.rs1     = instr[19:15];
        ctrl.rs2     = instr[24:20];
        ctrl.rd      = instr[11:7];
        rs1_used     = 1'b0;
        rs2_used     = 1'b0;
        bad          = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                ctrl.use_imm   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                rs1_used       = 1'b1;
            end
            OPC_STORE: begin
                ctrl.imm_sel   = IMM_S;
                ctrl.use_imm   = 1'b1;
                ctrl.mem_write = 1'b1;
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.imm_sel = IMM_B;
                ctrl.alu_op  = ALU_SUB;
                ctrl.branch  = 1'b1;
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
            end
            OPC_LUI: begin
                ctrl.imm_sel   = IMM_U;
                ctrl.alu_op    = ALU_PASSB;
                ctrl.use_imm   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.imm_sel   = IMM_U;
                ctrl.use_imm   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OPC_JAL: begin
                ctrl.imm_sel   = IMM_J;
                ctrl.use_imm   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
            end
            OPC_JALR: begin
                ctrl.use_imm   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                rs1_used       = 1'b1;
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
                bad            = !funct7_ok(funct7);
                case (funct3)
                    3'd0:    ctrl.alu_op = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                    3'd1:    ctrl.alu_op = ALU_SLL;
                    3'd2:    ctrl.alu_op = ALU_SLT;
                    3'd3:    ctrl.alu_op = ALU_SLTU;
                    3'd4:    ctrl.alu_op = ALU_XOR;
                    3'd5:    ctrl.alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    3'd6:    ctrl.alu_op = ALU_OR;
                    default: ctrl.alu_op = ALU_AND;
                endcase
            end
            OPC_OP_IMM: begin
                ctrl.use_imm   = 1'b1;
                ctrl.reg_write = 1'b1;
                rs1_used       = 1'b1;
                case (funct3)
                    3'd0: ctrl.alu_op = ALU_ADD;
                    3'd1: begin
                        ctrl.imm_sel = IMM_SHAMT;
                        ctrl.alu_op  = ALU_SLL;
                        bad          = (funct7 != F7_BASE);
                    end
                    3'd2: ctrl.alu_op = ALU_SLT;
                    3'd3: ctrl.alu_op = ALU_SLTU;
                    3'd4: ctrl.alu_op = ALU_XOR;
                    3'd5: begin
                        ctrl.imm_sel = IMM_SHAMT;
                        ctrl.alu_op  = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        bad          = !funct7_ok(funct7);
                    end
                    3'd6:    ctrl.alu_op = ALU_OR;
                    default: ctrl.alu_op = ALU_AND;
                endcase
            end
            default: bad = 1'b1;
        endcase

        // Illegal encodings still issue so EX can trap, but must not side-effect.
        if (bad) begin
            ctrl.imm_sel   = IMM_ILLEGAL;
            ctrl.illegal   = 1'b1;
            ctrl.reg_write = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.branch    = 1'b0;
            ctrl.jump      = 1'b0;
        end
    end

endmodule

// File: rtl/id_stage.sv
// Registered decode stage: valid/ready handshake on both sides, one-cycle
// load-use bubble, synchronous flush back to an empty NOP-holding register.
module id_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        flush,
    output logic        id_valid,
    input  logic        ex_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [2:0]  id_imm_sel,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic [3:0]  id_alu_op,
    output logic        id_use_imm,
    output logic        id_reg_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_branch,
    output logic        id_jump,
    output logic        id_illegal
);

    id_state_t state, state_next;
    ctrl_t     dec, held;
    logic      dec_rs1_used, dec_rs2_used;
    logic      in_xfer, out_xfer, hazard, capture;

    rv_decoder u_dec (
        .instr    (if_instr),
        .ctrl     (dec),
        .rs1_used (dec_rs1_used),
        .rs2_used (dec_rs2_used)
    );

    // Incoming instruction reads the destination of the load being issued.
    assign hazard = held.mem_read && (held.rd != 5'd0) &&
                    ((dec_rs1_used && (dec.rs1 == held.rd)) ||
                     (dec_rs2_used && (dec.rs2 == held.rd)));

    assign in_xfer  = if_valid && if_ready;
    assign out_xfer = id_valid && ex_ready;
    assign capture  = in_xfer && !flush;

    always_comb begin
        state_next = state;
        if_ready   = 1'b0;
        id_valid   = 1'b0;
        case (state)
            ST_EMPTY: begin
                if_ready = 1'b1;
                if (in_xfer) state_next = ST_FULL;
            end
            ST_FULL: begin
                id_valid = 1'b1;
                if_ready = ex_ready;
                if (out_xfer) begin
                    if (in_xfer) state_next = hazard ? ST_HAZARD : ST_FULL;
                    else         state_next = ST_EMPTY;
                end
            end
            ST_HAZARD: state_next = ST_FULL;
            default:   state_next = ST_EMPTY;
        endcase
        if (flush) state_next = ST_EMPTY;
        if (rst)   if_ready   = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            id_instr <= NOP_INSTR;
            id_pc    <= 32'd0;
            held     <= CTRL_CLEAR;
        end else begin
            state <= state_next;
            if (flush) begin
                id_instr <= NOP_INSTR;
                held     <= CTRL_CLEAR;
            end else if (capture) begin
                id_instr <= if_instr;
                id_pc    <= if_pc;
                held     <= dec;
            end
        end
    end

    assign id_imm_sel   = held.imm_sel;
    assign id_rs1       = held.rs1;
    assign id_rs2       = held.rs2;
    assign id_rd        = held.rd;
    assign id_alu_op    = held.alu_op;
    assign id_use_imm   = held.use_imm;
    assign id_reg_write = held.reg_write;
    assign id_mem_read  = held.mem_read;
    assign id_mem_write = held.mem_write;
    assign id_branch    = held.branch;
    assign id_jump      = held.jump;
    assign id_illegal   = held.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the stage.
module tb_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, if_valid, if_ready, flush, id_valid, ex_ready;
    logic [31:0] if_instr, if_pc, id_instr, id_pc;
    logic [2:0]  id_imm_sel;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_use_imm, id_reg_write, id_mem_read, id_mem_write;
    logic        id_branch, id_jump, id_illegal;
    logic [13:0] dut_ctl;

    always #5 clk = ~clk;

    id_stage #(.NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .id_valid(id_valid),
        .ex_ready(ex_ready), .id_instr(id_instr), .id_pc(id_pc),
        .id_imm_sel(id_imm_sel), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .id_jump(id_jump), .id_illegal(id_illegal)
    );

    assign dut_ctl = {id_imm_sel, id_alu_op, id_use_imm, id_reg_write, id_mem_read,
                      id_mem_write, id_branch, id_jump, id_illegal};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode from the instruction-set rules.
    // Packing: {rs1_used, rs2_used, imm_sel[2:0], alu[3:0], use_imm, reg_write,
    //           mem_read, mem_write, branch, jump, illegal}
    function automatic logic [15:0] ref_ctl(input logic [31:0] i);
        logic [6:0] op, f7;
        logic [2:0] f3, sel;
        logic [3:0] alu;
        logic       r1, r2, ui, rw, mr, mw, br, jp, il;
        logic [3:0] base_alu [8];
        base_alu = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        {r1, r2, ui, rw, mr, mw, br, jp, il} = '0;
        sel = 3'd0; alu = 4'd0;
        case (op)
            7'h03: begin r1 = 1; ui = 1; rw = 1; mr = 1; end
            7'h23: begin r1 = 1; r2 = 1; ui = 1; mw = 1; sel = 3'd1; end
            7'h63: begin r1 = 1; r2 = 1; br = 1; sel = 3'd2; alu = 4'd1; end
            7'h37: begin ui = 1; rw = 1; sel = 3'd3; alu = 4'd10; end
            7'h17: begin ui = 1; rw = 1; sel = 3'd3; end
            7'h6F: begin ui = 1; rw = 1; jp = 1; sel = 3'd4; end
            7'h67: begin r1 = 1; ui = 1; rw = 1; jp = 1; end
            7'h33: begin
                r1 = 1; r2 = 1; rw = 1;
                alu = base_alu[f3] + (((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5)) ? 4'd1 : 4'd0);
                il = !(f7 == 7'h00 || f7 == 7'h20);
            end
            7'h13: begin
                r1 = 1; ui = 1; rw = 1;
                if (f3 == 3'd1) begin
                    sel = 3'd6; alu = 4'd2; il = (f7 != 7'h00);
                end else if (f3 == 3'd5) begin
                    sel = 3'd6; alu = (f7 == 7'h20) ? 4'd7 : 4'd6;
                    il = !(f7 == 7'h00 || f7 == 7'h20);
                end else begin
                    alu = base_alu[f3];
                end
            end
            default: il = 1;
        endcase
        if (il) begin sel = 3'd7; {rw, mr, mw, br, jp} = '0; end
        return {r1, r2, sel, alu, ui, rw, mr, mw, br, jp, il};
    endfunction

    logic        m_valid, m_bubble;
    logic [31:0] m_instr, m_pc;
    logic [15:0] m_ctl;
    int          cyc = 0;
    int          issue_cyc [$];
    logic [2:0]  issue_sel [$];

    task automatic model_reset();
        m_valid = 0; m_bubble = 0; m_instr = NOP; m_pc = 0; m_ctl = '0;
    endtask

    // One clock: drive at negedge, check, advance model at posedge, return at next negedge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic er, input logic fl);
        logic        exp_rdy, take, issue, haz;
        logic [15:0] nc;
        logic [4:0]  drd;
        if_valid = v; if_instr = ins; if_pc = pc; ex_ready = er; flush = fl;
        #1;
        exp_rdy = !m_bubble && (!m_valid || er);
        chk("if_ready", 64'(if_ready), 64'(exp_rdy));
        chk("id_valid", 64'(id_valid), 64'(m_valid));
        chk("id_instr", 64'(id_instr), 64'(m_instr));
        chk("id_pc", 64'(id_pc), 64'(m_pc));
        chk("id_regs", 64'({id_rs1, id_rs2, id_rd}),
            64'({m_instr[19:15], m_instr[24:20], m_instr[11:7]}));
        chk("id_ctl", 64'(dut_ctl), 64'(m_ctl[13:0]));
        take  = v && exp_rdy;
        issue = m_valid && er;
        if (issue) begin
            issue_cyc.push_back(cyc);
            issue_sel.push_back(id_imm_sel);
        end
        @(posedge clk);
        if (fl) begin
            m_valid = 0; m_bubble = 0; m_instr = NOP; m_ctl = '0;
        end else if (m_bubble) begin
            m_bubble = 0; m_valid = 1;
        end else if (take) begin
            nc  = ref_ctl(ins);
            drd = m_instr[11:7];
            haz = issue && m_ctl[4] && (drd != 5'd0) &&
                  ((nc[15] && ins[19:15] == drd) || (nc[14] && ins[24:20] == drd));
            m_instr = ins; m_pc = pc; m_ctl = nc;
            m_valid = !haz; m_bubble = haz;
        end else if (issue) begin
            m_valid = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        logic [6:0]  ops [10];
        int          r;
        ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h7F};
        i = $urandom;
        i[6:0]   = ops[$urandom_range(0, 9)];
        i[11:7]  = 5'($urandom_range(0, 3));
        i[19:15] = 5'($urandom_range(0, 3));
        i[24:20] = 5'($urandom_range(0, 3));
        r = $urandom_range(0, 7);
        if (r < 4)      i[31:25] = 7'h00;
        else if (r < 6) i[31:25] = 7'h20;
        return i;
    endfunction

    localparam logic [31:0] ADDI  = 32'h0050_0093;
    localparam logic [31:0] LW5   = 32'h0001_2283;
    localparam logic [31:0] ADD6  = 32'h0012_8333;
    localparam logic [31:0] LW0   = 32'h0001_2003;
    localparam logic [31:0] ADDX0 = 32'h0010_0333;
    localparam logic [31:0] LUI3  = 32'h1234_51B7;
    localparam logic [31:0] ILLOP = 32'h0000_007F;
    localparam logic [31:0] ADDF1 = 32'h0212_8333;

    initial begin
        logic [31:0] stream [5];
        logic [2:0]  sel_exp [5];
        int          n0;
        stream  = '{32'h0020_A223, 32'h0020_8463, LUI3, 32'h0100_00EF, 32'h4030_D213};
        sel_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6};

        rst = 1; if_valid = 0; if_instr = 0; if_pc = 0; flush = 0; ex_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 64'(id_valid), 64'd0);
        chk("rst_ready", 64'(if_ready), 64'd0);
        chk("rst_instr", 64'(id_instr), 64'(NOP));
        chk("rst_pc", 64'(id_pc), 64'd0);
        chk("rst_ctl", 64'({dut_ctl, id_rs1, id_rs2, id_rd}), 64'd0);
        rst = 0;
        @(negedge clk);

        // single ADDI
        step(1, ADDI, 32'h100, 1, 0);
        chk("addi_valid", 64'(id_valid), 64'd1);
        chk("addi_sel", 64'(id_imm_sel), 64'd0);
        chk("addi_rd", 64'(id_rd), 64'd1);
        chk("addi_flags", 64'({id_use_imm, id_reg_write, id_alu_op}), 64'({1'b1, 1'b1, 4'd0}));
        step(0, 0, 0, 1, 0);

        // back-to-back stream
        issue_cyc.delete(); issue_sel.delete();
        for (int k = 0; k < 5; k++) step(1, stream[k], 32'h200 + 32'(4 * k), 1, 0);
        chk("srai_alu", 64'(id_alu_op), 64'd7);
        step(0, 0, 0, 1, 0);
        chk("stream_n", 64'(issue_cyc.size()), 64'd5);
        for (int k = 0; k < 5 && k < issue_cyc.size(); k++) begin
            chk("stream_cyc", 64'(issue_cyc[k] - issue_cyc[0]), 64'(k));
            chk("stream_sel", 64'(issue_sel[k]), 64'(sel_exp[k]));
        end

        // load-use bubble, then the x0 case with none
        step(1, LW5, 32'h300, 1, 0);
        step(1, ADD6, 32'h304, 1, 0);
        chk("lu_bubble", 64'(id_valid), 64'd0);
        step(0, 0, 0, 1, 0);
        chk("lu_add_valid", 64'(id_valid), 64'd1);
        chk("lu_add_instr", 64'(id_instr), 64'(ADD6));
        step(0, 0, 0, 1, 0);
        step(1, LW0, 32'h310, 1, 0);
        step(1, ADDX0, 32'h314, 1, 0);
        chk("nb_valid", 64'(id_valid), 64'd1);
        chk("nb_instr", 64'(id_instr), 64'(ADDX0));
        step(0, 0, 0, 1, 0);

        // EX stall for three cycles
        step(1, ADDI, 32'h400, 1, 0);
        issue_cyc.delete(); issue_sel.delete();
        for (int k = 0; k < 3; k++) begin
            step(1, ADD6, 32'h404, 0, 0);
            chk("stall_instr", 64'(id_instr), 64'(ADDI));
            chk("stall_pc", 64'(id_pc), 64'h400);
        end
        step(0, 0, 0, 1, 0);
        chk("stall_issues", 64'(issue_cyc.size()), 64'd1);
        chk("stall_drained", 64'(id_valid), 64'd0);

        // flush with an incoming instruction
        step(1, ADDI, 32'h500, 1, 0);
        step(1, LUI3, 32'h504, 1, 1);
        chk("flush_valid", 64'(id_valid), 64'd0);
        chk("flush_instr", 64'(id_instr), 64'(NOP));
        step(0, 0, 0, 1, 0);
        chk("flush_no_issue", 64'(id_valid), 64'd0);

        // illegal encodings still issue
        step(1, ILLOP, 32'h600, 1, 0);
        chk("ill_op", 64'({id_valid, id_illegal, id_imm_sel, id_reg_write}),
            64'({1'b1, 1'b1, 3'd7, 1'b0}));
        step(1, ADDF1, 32'h604, 1, 0);
        chk("ill_f7", 64'({id_valid, id_illegal, id_imm_sel, id_reg_write}),
            64'({1'b1, 1'b1, 3'd7, 1'b0}));
        step(0, 0, 0, 1, 0);

        // random traffic
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);

        // reset asserted while holding an instruction
        step(0, 0, 0, 1, 0);
        step(1, ADDI, 32'h700, 0, 0);
        rst = 1;
        #1;
        chk("mid_rst_valid", 64'(id_valid), 64'd0);
        chk("mid_rst_ready", 64'(if_ready), 64'd0);
        chk("mid_rst_instr", 64'(id_instr), 64'(NOP));
        @(negedge clk);
        rst = 0;
        model_reset();
        step(0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Registered instruction-decode stage between instruction fetch and execute. It captures one fetched instruction per handshake, decodes it into a control bundle, and presents the raw instruction and a 3-bit immediate selector to the immediate generator (`imm_data` / `data_type`). It inserts a one-cycle bubble on a load-use dependency and supports a synchronous pipeline flush.

## Interface
Parameters:
- NOP_INSTR, 32'h0000_0013, instruction word loaded into `id_instr` on reset and flush.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  stage accepts an instruction this cycle.
- if_instr  in  32  fetched instruction.
- if_pc  in  32  PC of `if_instr`.
- flush  in  1  kill the held instruction and any incoming instruction.
- id_valid  out  1  decoded instruction available to EX.
- ex_ready  in  1  EX accepts this cycle.
- id_instr  out  32  held instruction; drives immediate generator `imm_data`.
- id_pc  out  32  held PC.
- id_imm_sel  out  3  immediate format; drives immediate generator `data_type`.
- id_rs1, id_rs2, id_rd  out  5 each  register indices.
- id_alu_op  out  4  ALU operation.
- id_use_imm, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal  out  1 each  control flags.

## Operation
- Handshakes: input transfer when `if_valid && if_ready`; output transfer when `id_valid && ex_ready`.
- FSM states: EMPTY, FULL, HAZARD.
  - EMPTY: `id_valid=0`, `if_ready=1`. On input transfer, go to FULL.
  - FULL: `id_valid=1`, `if_ready=ex_ready`.
    - Transfer out with no input transfer: go to EMPTY.
    - Transfer out with a simultaneous input transfer: capture the new instruction and go to FULL, or to HAZARD if the load-use check fires.
    - No transfer out: hold all outputs.
  - HAZARD: `id_valid=0`, `if_ready=0` for exactly one cycle, then FULL.
- Load-use check, evaluated only when capturing in the same cycle as an issue:
  - Fires if the issuing instruction has `id_mem_read=1` and `id_rd!=0`.
  - And the captured instruction reads a matching register: rs1 matches (for R, I, S, B, JALR), or rs2 matches (for R, S, B).
  - Capture from EMPTY never fires the check.
- Flush (synchronous, highest priority below reset):
  - Next state is EMPTY.
  - An input transfer in the same cycle is discarded.
  - `id_instr` is set to NOP_INSTR and all control flags are cleared.
- Decode happens combinationally on `if_instr` and is registered on capture. `id_imm_sel` encoding:
  - 0 = I: loads, JALR, OP-IMM except shifts; also R-type, with `id_use_imm=0`.
  - 1 = S: stores.
  - 2 = B: branches.
  - 3 = U: LUI, AUIPC.
  - 4 = J: JAL.
  - 6 = shamt: SLLI, SRLI, SRAI.
  - 7 = illegal.
  - Code 5 is never produced.
- ALU op encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
  - LUI uses PASSB.
  - AUIPC, loads, stores, JAL and JALR use ADD.
  - Branches use SUB.
- Illegal instruction: unknown opcode, R-type funct7 not in {0x00, 0x20}, or a shift-immediate with a bad funct7.
  - Sets `id_illegal=1` and `id_imm_sel=7`.
  - Clears reg_write, mem_read, mem_write, branch and jump.
  - Still issued normally so EX can trap.

## Timing
- Reset values: state EMPTY; `id_valid=0`; `id_instr=NOP_INSTR`; `id_pc=0`; `id_imm_sel=0`; all indices, `id_alu_op` and flags 0. `if_ready` is forced to 0 while `rst` is high.
- Latency: input transfer at edge k gives `id_valid=1` in cycle k+1, or k+2 on load-use.
- Throughput: one instruction per cycle with `ex_ready` held high and no hazards.
- `if_ready` in FULL depends combinationally on `ex_ready`; no other combinational input-to-output paths.
- Reset asserted mid-operation discards the held instruction immediately.
- Outputs are stable while `id_valid && !ex_ready`.

## Structure
- Shared package `riscv_pkg`: `imm_sel_t` (3-bit enum above), `alu_op_t` (4-bit enum above), opcode constants, `id_state_t`.
- One combinational sub-module `rv_decoder` maps instr[31:0] to a decoded control struct. `id_stage` holds the FSM, the pipeline registers and the hazard compare.

## Test plan
- Reset, then `if_valid` with 0x00500093 (addi x1,x0,5) and `ex_ready=1`:
  - `id_valid` rises next cycle; `id_imm_sel=0`, `id_rd=1`, `id_use_imm=1`, `id_reg_write=1`, `id_alu_op=0`.
- Back-to-back stream of SW, BEQ, LUI, JAL, SRAI with `ex_ready=1`:
  - One issue per cycle.
  - `id_imm_sel` sequence is 1, 2, 3, 4, 6.
  - SRAI gives `id_alu_op=7`.
- LW x5,0(x2) followed directly by ADD x6,x5,x1:
  - `id_valid` goes low for exactly one cycle after the LW issue, then the ADD issues.
  - The same pair with x0 as the load destination causes no bubble.
- FULL with `ex_ready=0` for 3 cycles:
  - All outputs stable and `if_ready=0`.
  - Releasing `ex_ready` issues once.
- `flush` asserted while FULL and `if_valid=1`:
  - Next cycle EMPTY, `id_valid=0`, `id_instr=0x00000013`.
  - The incoming instruction is not issued.
- Opcode 0x7F, and ADD with funct7=0x01:
  - `id_illegal=1`, `id_imm_sel=7`, `id_reg_write=0`, and the instruction is still issued.
